// File: rtl/nock_mem_pkg.sv
// Shared encodings for the nock memory responder: request functions, error bit
// positions, FSM states and default widths. MEM_SCRUB_EN adds the SCRUB state.
package nock_mem_pkg;

    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DATA_WIDTH = 68;
    localparam int DEF_DEPTH      = 1024;
    localparam int DEF_FREE_BASE  = 0;

    typedef enum logic [1:0] {
        GET_CONTENTS = 2'b00,
        SET_CONTENTS = 2'b01,
        ALLOC        = 2'b10,
        FUNC_RSVD    = 2'b11
    } mem_func_e;

    localparam int ERR_REQ_WHILE_BUSY = 0;
    localparam int ERR_ADDR_RANGE     = 1;
    localparam int ERR_OUT_OF_MEM     = 2;
    localparam int ERR_BAD_FUNC       = 3;

`ifdef MEM_SCRUB_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10,
        ST_SCRUB  = 2'b11
    } mem_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } mem_state_e;
`endif

endpackage

// File: rtl/nock_mem_ram.sv
// Single-port synchronous RAM, DEPTH x DATA_WIDTH, one-cycle read latency,
// write-first: a write returns the written word on the read port.
module nock_mem_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 68,
    parameter int DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [IDX_W-1:0]      idx_s;

    assign idx_s = addr[IDX_W-1:0];

    generate
        if (IDX_W < ADDR_WIDTH) begin : g_hi_bits
            // Callers never present an address >= DEPTH, so the upper bits carry no information.
            logic unused_hi_s;
            assign unused_hi_s = ^addr[ADDR_WIDTH-1:IDX_W];
        end
    endgenerate

    // Storage array and registered read port.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[idx_s] <= wdata;
                rdata_q      <= wdata;
            end else begin
                rdata_q <= mem_q[idx_s];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/nock_mem_unit.sv
// Responder for execute/traversal memory requests: GET/SET/ALLOC on an internal
// RAM with a bump-allocated free pointer. MEM_SCRUB_EN zeroes the RAM after reset.
module nock_mem_unit
    import nock_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int FREE_BASE  = DEF_FREE_BASE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_execute,
    input  logic [1:0]            mem_func,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  mem_ready,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic [ADDR_WIDTH-1:0] free_addr,
    output logic                  mem_idle,
    output logic [3:0]            mem_error
);

    // Pointers carry one extra bit so DEPTH == 2**ADDR_WIDTH is representable as "full".
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] BASE_L  = (ADDR_WIDTH+1)'(FREE_BASE);
    localparam logic [ADDR_WIDTH:0] ONE_L   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    mem_state_e            state_q, state_d;
    mem_func_e             func_q, func_d, req_func_s;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  oob_q, oob_d;
    logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
    logic                  mem_ready_q, mem_ready_d;
    logic [ADDR_WIDTH:0]   free_q, free_d;
    logic [3:0]            mem_error_q, mem_error_d;
    logic                  full_s, range_err_s;
    logic                  ram_en_s, ram_we_s;
    logic [ADDR_WIDTH-1:0] ram_addr_s;
    logic [DATA_WIDTH-1:0] ram_wdata_s, ram_rdata_s;
`ifdef MEM_SCRUB_EN
    logic [ADDR_WIDTH:0]   scrub_q, scrub_d;
`endif

    assign req_func_s  = mem_func_e'(mem_func);
    assign full_s      = (free_q >= DEPTH_L);
    assign range_err_s = ({1'b0, address} >= DEPTH_L);

    // Next-state, RAM control and output computation.
    always_comb begin
        state_d     = state_q;
        func_d      = func_q;
        addr_d      = addr_q;
        oob_d       = oob_q;
        read_data_d = read_data_q;
        mem_ready_d = 1'b0;
        free_d      = free_q;
        mem_error_d = mem_error_q;
        ram_en_s    = 1'b0;
        ram_we_s    = 1'b0;
        ram_addr_s  = address;
        ram_wdata_s = write_data;
`ifdef MEM_SCRUB_EN
        scrub_d     = scrub_q;
`endif
        if (mem_execute && (state_q != ST_IDLE)) begin
            mem_error_d[ERR_REQ_WHILE_BUSY] = 1'b1;
        end else begin
            mem_error_d[ERR_REQ_WHILE_BUSY] = mem_error_q[ERR_REQ_WHILE_BUSY];
        end
        case (state_q)
            ST_IDLE: begin
                if (mem_execute) begin
                    state_d = ST_ACCESS;
                    func_d  = req_func_s;
                    addr_d  = address;
                    oob_d   = range_err_s;
                    case (req_func_s)
                        GET_CONTENTS, SET_CONTENTS: begin
                            ram_en_s = ~range_err_s;
                            ram_we_s = (req_func_s == SET_CONTENTS);
                            mem_error_d[ERR_ADDR_RANGE] = mem_error_q[ERR_ADDR_RANGE] | range_err_s;
                        end
                        ALLOC: begin
                            addr_d     = free_q[ADDR_WIDTH-1:0];
                            oob_d      = full_s;
                            ram_en_s   = ~full_s;
                            ram_we_s   = 1'b1;
                            ram_addr_s = free_q[ADDR_WIDTH-1:0];
                            free_d     = full_s ? free_q : (free_q + ONE_L);
                            mem_error_d[ERR_OUT_OF_MEM] = mem_error_q[ERR_OUT_OF_MEM] | full_s;
                        end
                        default: begin
                            mem_error_d[ERR_BAD_FUNC] = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                state_d     = ST_RESP;
                mem_ready_d = 1'b1;
                case (func_q)
                    GET_CONTENTS: read_data_d = oob_q ? {DATA_WIDTH{1'b0}} : ram_rdata_s;
                    ALLOC:        read_data_d = oob_q ? {DATA_WIDTH{1'b1}}
                                                      : {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, addr_q};
                    default:      read_data_d = read_data_q;
                endcase
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
`ifdef MEM_SCRUB_EN
            ST_SCRUB: begin
                if (scrub_q == DEPTH_L) begin
                    state_d = ST_IDLE;
                end else begin
                    ram_en_s    = 1'b1;
                    ram_we_s    = 1'b1;
                    ram_addr_s  = scrub_q[ADDR_WIDTH-1:0];
                    ram_wdata_s = {DATA_WIDTH{1'b0}};
                    scrub_d     = scrub_q + ONE_L;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef MEM_SCRUB_EN
            state_q <= ST_SCRUB;
            scrub_q <= {(ADDR_WIDTH+1){1'b0}};
`else
            state_q <= ST_IDLE;
`endif
            func_q      <= GET_CONTENTS;
            addr_q      <= {ADDR_WIDTH{1'b0}};
            oob_q       <= 1'b0;
            read_data_q <= {DATA_WIDTH{1'b0}};
            mem_ready_q <= 1'b0;
            free_q      <= BASE_L;
            mem_error_q <= 4'b0000;
        end else begin
`ifdef MEM_SCRUB_EN
            scrub_q <= scrub_d;
`endif
            state_q     <= state_d;
            func_q      <= func_d;
            addr_q      <= addr_d;
            oob_q       <= oob_d;
            read_data_q <= read_data_d;
            mem_ready_q <= mem_ready_d;
            free_q      <= free_d;
            mem_error_q <= mem_error_d;
        end
    end

    nock_mem_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en_s),
        .we    (ram_we_s),
        .addr  (ram_addr_s),
        .wdata (ram_wdata_s),
        .rdata (ram_rdata_s)
    );

    assign mem_ready = mem_ready_q;
    assign read_data = read_data_q;
    assign free_addr = free_q[ADDR_WIDTH-1:0];
    assign mem_idle  = (state_q == ST_IDLE);
    assign mem_error = mem_error_q;

endmodule

// File: tb/tb_nock_mem_unit.sv
// Scoreboard bench for nock_mem_unit: expected completions are queued at issue
// and compared when mem_ready is seen. Build with MEM_SCRUB_EN to cover scrubbing.
module tb_nock_mem_unit;
    import nock_mem_pkg::*;

    localparam int AW  = 10;
    localparam int DW  = 68;
    localparam int DEP = 512;
    localparam int IW  = 9;
`ifdef MEM_SCRUB_EN
    localparam bit SCRUB = 1'b1;
`else
    localparam bit SCRUB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_execute = 1'b0;
    logic [1:0]    mem_func = 2'b00;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] write_data = '0;
    logic          mem_ready;
    logic [DW-1:0] read_data;
    logic [AW-1:0] free_addr;
    logic          mem_idle;
    logic [3:0]    mem_error;

    nock_mem_unit #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEP),
        .FREE_BASE  (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_execute (mem_execute),
        .mem_func    (mem_func),
        .address     (address),
        .write_data  (write_data),
        .mem_ready   (mem_ready),
        .read_data   (read_data),
        .free_addr   (free_addr),
        .mem_idle    (mem_idle),
        .mem_error   (mem_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [DW-1:0] exp;
        int            cyc;
    } sb_t;
    sb_t sb[$];

    // Reference state
    logic [DW-1:0] model_mem [DEP];
    int            model_free;
    logic [DW-1:0] last_rd;
    logic [3:0]    model_err;

    // Completion monitor: every mem_ready must match the oldest queued request.
    always @(negedge clk) begin
        if (!rst && mem_ready) begin
            check_eq("ready_pending", DW'(sb.size() > 0), DW'(1'b1));
            if (sb.size() > 0) begin
                sb_t e;
                e = sb.pop_front();
                check_eq("ready_latency", DW'(cyc), DW'(e.cyc + 2));
                check_eq("read_data", read_data, e.exp);
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 8 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check_eq("ready_timeout", DW'(sb.size()), DW'(0));
            sb.delete();
        end
    endtask

    task automatic send(input logic [1:0] f, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [DW-1:0] e;
        case (f)
            2'b00: begin
                if (int'(a) >= DEP) begin
                    e = '0;
                    model_err[1] = 1'b1;
                end else begin
                    e = model_mem[a[IW-1:0]];
                end
            end
            2'b01: begin
                if (int'(a) >= DEP) model_err[1] = 1'b1;
                else model_mem[a[IW-1:0]] = d;
                e = last_rd;
            end
            2'b10: begin
                if (model_free >= DEP) begin
                    e = '1;
                    model_err[2] = 1'b1;
                end else begin
                    model_mem[IW'(model_free)] = d;
                    e = DW'(model_free);
                    model_free++;
                end
            end
            default: begin
                e = last_rd;
                model_err[3] = 1'b1;
            end
        endcase
        last_rd = e;
        @(negedge clk);
        mem_execute = 1'b1;
        mem_func    = f;
        address     = a;
        write_data  = d;
        sb.push_back('{e, cyc});
        @(negedge clk);
        mem_execute = 1'b0;
        wait_drain();
        check_eq("free_addr", DW'(free_addr), DW'(model_free));
        check_eq("mem_error", DW'(mem_error), DW'(model_err));
    endtask

    // Caller is at a negedge (or time 0).
    task automatic reset_dut();
        int n;
        rst = 1'b1;
        mem_execute = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        model_free = 0;
        last_rd    = '0;
        model_err  = 4'b0000;
        for (int i = 0; i < DEP; i++) model_mem[IW'(i)] = '0;
        check_eq("rst_ready", DW'(mem_ready), DW'(1'b0));
        check_eq("rst_read_data", read_data, DW'(0));
        check_eq("rst_free_addr", DW'(free_addr), DW'(0));
        check_eq("rst_mem_error", DW'(mem_error), DW'(0));
        check_eq("rst_idle", DW'(mem_idle), DW'(!SCRUB));
        n = 0;
        while (!mem_idle && n < DEP + 20) begin
            @(negedge clk);
            n++;
        end
`ifdef MEM_SCRUB_EN
        check_eq("scrub_cycles", DW'(n), DW'(DEP + 1));
`endif
    endtask

    logic [DW-1:0] dat_a, dat_b, dat_c;

    initial begin
        reset_dut();

        // Basic SET/GET, then range and reserved-function handling.
        send(2'b01, 10'h005, 68'h0123456789ABCDEF0);
        send(2'b00, 10'h005, '0);
        send(2'b00, 10'h3FF, '0);
        send(2'b00, 10'h005, '0);
        send(2'b11, 10'h005, 68'hF_FFFF_0000_FFFF_0000);
        send(2'b01, 10'h205, 68'hA_AAAA_AAAA_AAAA_AAAA);
        send(2'b00, 10'h005, '0);

        // Allocation from a fresh reset.
        @(negedge clk);
        reset_dut();
`ifdef MEM_SCRUB_EN
        send(2'b00, 10'd300, '0);
        send(2'b00, 10'd7, '0);
`endif
        dat_a = 68'h1_1111_2222_3333_4444;
        dat_b = 68'h2_5555_6666_7777_8888;
        dat_c = 68'h3_9999_AAAA_BBBB_CCCC;
        send(2'b10, '0, dat_a);
        send(2'b10, '0, dat_b);
        send(2'b10, '0, dat_c);
        send(2'b00, 10'd1, '0);

        // Requests in the ACCESS and RESP cycles are dropped.
        @(negedge clk);
        mem_execute = 1'b1;
        mem_func    = 2'b00;
        address     = 10'd1;
        sb.push_back('{model_mem[1], cyc});
        last_rd = model_mem[1];
        @(negedge clk);
        mem_func   = 2'b01;
        write_data = 68'hD_EADB_EEFD_EADB_EEF0;
        @(negedge clk);
        @(negedge clk);
        mem_execute = 1'b0;
        model_err[0] = 1'b1;
        wait_drain();
        check_eq("busy_error", DW'(mem_error), DW'(model_err));
        send(2'b00, 10'd1, '0);

        // Fill the heap, then allocate once more when full.
        while (model_free < DEP) send(2'b10, '0, DW'({$urandom(), $urandom(), $urandom()}));
        send(2'b10, '0, 68'h7_7777_7777_7777_7777);
        send(2'b00, 10'd0, '0);
        send(2'b00, 10'd511, '0);

        // Reset while a GET is in its ACCESS cycle.
        @(negedge clk);
        mem_execute = 1'b1;
        mem_func    = 2'b00;
        address     = 10'd2;
        @(negedge clk);
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            check_eq("no_ready_after_rst", DW'(mem_ready), DW'(1'b0));
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
